// File: rtl/tlb_lookup.sv
// Two-stage pipelined TLB lookup. It translates {vaddr, asid, plv, access type}
// into a physical address, a memory type and a translation exception, using the
// live entry array from the TLB storage block.

package tlb_pkg;

    // One page half (even or odd) of a TLB entry
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_half_t;

    // Full TLB entry as produced by the storage block
    typedef struct packed {
        logic        e;
        logic [18:0] vpn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        tlb_half_t   p0;
        tlb_half_t   p1;
    } tlb_entry_t;

    // Translation exception codes
    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIL  = 3'd2,
        EXC_PIS  = 3'd3,
        EXC_PIF  = 3'd4,
        EXC_PPI  = 3'd5,
        EXC_PME  = 3'd6
    } exc_e;

endpackage

module tlb_lookup
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 16,
    localparam int IW = $clog2(TLB_ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  tlb_entry_t       entries_i [TLB_ENTRY_NUM],
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_vaddr_i,
    input  logic [9:0]       req_asid_i,
    input  logic [1:0]       req_plv_i,
    input  logic             req_store_i,
    input  logic             req_fetch_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_paddr_o,
    output logic [1:0]       resp_mat_o,
    output logic             resp_hit_o,
    output logic [IW-1:0]    resp_index_o,
    output logic [2:0]       resp_exc_o
);

    // Does one entry translate this request?
    function automatic logic entry_match(input tlb_entry_t ent,
                                         input logic [31:0] va,
                                         input logic [9:0]  asid);
        return ent.e && (ent.g || ent.asid == asid) &&
               ent.vpn[18:10] == va[31:23] &&
               (ent.ps == 6'd21 || ent.vpn[9:0] == va[22:13]);
    endfunction

    logic           s1_valid;
    logic           s1_hit;
    logic [IW-1:0]  s1_index;
    tlb_half_t      s1_half;
    logic           s1_ps21;
    logic [20:0]    s1_va_low;
    logic [1:0]     s1_plv;
    logic           s1_store;
    logic           s1_fetch;

    logic           match_hit;
    logic [IW-1:0]  match_idx;
    tlb_entry_t     sel_entry;
    logic           sel_odd;
    tlb_half_t      sel_half;

    logic           s2_adv;
    logic           s1_adv;

    logic [31:0]    s2_paddr;
    logic [1:0]     s2_mat;
    exc_e           s2_exc;

    assign s2_adv      = !resp_valid_o || resp_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign req_ready_o = !rst && !flush_i && s1_adv;

    // Parallel compare; scanning downward lets the lowest matching index win
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
            if (entry_match(entries_i[i], req_vaddr_i, req_asid_i)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    // Pick the page half addressed by the request inside the winning entry
    always_comb begin
        sel_entry = entries_i[match_idx];
        sel_odd   = (sel_entry.ps == 6'd21) ? req_vaddr_i[21] : req_vaddr_i[12];
        sel_half  = sel_odd ? sel_entry.p1 : sel_entry.p0;
    end

    // Stage 1: snapshot the selected half so later entry writes cannot leak in
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_hit    <= 1'b0;
            s1_index  <= '0;
            s1_half   <= '0;
            s1_ps21   <= 1'b0;
            s1_va_low <= '0;
            s1_plv    <= '0;
            s1_store  <= 1'b0;
            s1_fetch  <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= req_valid_i;
            if (req_valid_i) begin
                s1_hit    <= match_hit;
                s1_index  <= match_idx;
                s1_half   <= match_hit ? sel_half : '0;
                s1_ps21   <= match_hit && (sel_entry.ps == 6'd21);
                s1_va_low <= req_vaddr_i[20:0];
                s1_plv    <= req_plv_i;
                s1_store  <= req_store_i;
                s1_fetch  <= req_fetch_i;
            end
        end
    end

    // Stage 2 combinational: physical address and prioritised exception
    always_comb begin
        s2_exc   = EXC_NONE;
        s2_paddr = '0;
        s2_mat   = '0;
        if (!s1_hit) begin
            s2_exc = EXC_TLBR;
        end else if (!s1_half.v) begin
            s2_exc = s1_fetch ? EXC_PIF : (s1_store ? EXC_PIS : EXC_PIL);
        end else begin
            s2_paddr = s1_ps21 ? {s1_half.ppn[19:9], s1_va_low}
                               : {s1_half.ppn, s1_va_low[11:0]};
            s2_mat   = s1_half.mat;
            if (s1_plv > s1_half.plv) begin
                s2_exc = EXC_PPI;
            end else if (s1_store && !s1_half.d) begin
                s2_exc = EXC_PME;
            end
        end
    end

    // Output stage: load when free or consumed, otherwise hold the response stable
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_o <= 1'b0;
            resp_paddr_o <= '0;
            resp_mat_o   <= '0;
            resp_hit_o   <= 1'b0;
            resp_index_o <= '0;
            resp_exc_o   <= '0;
        end else if (flush_i) begin
            resp_valid_o <= 1'b0;
        end else if (s2_adv) begin
            resp_valid_o <= s1_valid;
            if (s1_valid) begin
                resp_paddr_o <= s2_paddr;
                resp_mat_o   <= s2_mat;
                resp_hit_o   <= s1_hit;
                resp_index_o <= s1_index;
                resp_exc_o   <= s2_exc;
            end
        end
    end

endmodule
